// File: rtl/prog_end_pkg.sv
// Shared types and constants for the end-of-program monitor: FSM states,
// default halt/timeout values and the 2-bit result status encoding.
package prog_end_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  localparam logic [63:0] DEF_HALT_PC        = 64'h0000_0000_0000_001c;
  localparam int          DEF_TIMEOUT_CYCLES = 10000000;

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_PASS    = 2'd1;
  localparam logic [1:0] RES_FAIL    = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  // Status code to one-hot {timeout, fail, pass}.
  function automatic logic [2:0] res_flags(input logic [1:0] code);
    case (code)
      RES_PASS:    return 3'b001;
      RES_FAIL:    return 3'b010;
      RES_TIMEOUT: return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/prog_end_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable and
// the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         cnt <= '0;
    else if (clr)                     cnt <= '0;
    else if (en && (cnt != {W{1'b1}})) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/prog_end_monitor.sv
// End-of-program monitor on the commit stream: qualifies a self-loop halt,
// grades gp (x3) as pass/fail, or flags a timeout. Optional PC trace buffer
// is enabled with PROG_END_TRACE_EN.
module prog_end_monitor
  import prog_end_pkg::*;
#(
  parameter logic [63:0] HALT_PC        = DEF_HALT_PC,
  parameter int          STABLE_COMMITS = 2,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             commit_valid,
  input  logic [63:0]      commit_pc,
  input  logic [63:0]      gp_value,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [63:0]      result_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
`ifdef PROG_END_TRACE_EN
  ,
  input  logic [2:0]       trace_idx,
  output logic [63:0]      trace_pc
`endif
);

  localparam int MW = $clog2(STABLE_COMMITS + 1);

  state_t        state;
  logic [MW-1:0] match_cnt;
  logic          hit, qualify, cyc_last, in_run;
  logic [1:0]    chk_code;

  assign in_run   = (state == S_RUN);
  assign hit      = commit_valid && (commit_pc == HALT_PC);
  assign qualify  = in_run && hit && (match_cnt >= MW'(STABLE_COMMITS - 1));
  assign cyc_last = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign chk_code = (gp_value == '0) ? RES_PASS : RES_FAIL;

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (in_run || (state == S_CHECK)),
    .cnt (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instret (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (in_run && commit_valid),
    .cnt (instret_count)
  );

  // start restarts from any state, including mid-RUN and terminal states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= S_IDLE;
      match_cnt             <= '0;
      result_code           <= '0;
      running               <= 1'b0;
      done                  <= 1'b0;
      {timeout, fail, pass} <= res_flags(RES_NONE);
    end else if (start) begin
      state                 <= S_RUN;
      match_cnt             <= '0;
      result_code           <= '0;
      running               <= 1'b1;
      done                  <= 1'b0;
      {timeout, fail, pass} <= res_flags(RES_NONE);
    end else begin
      case (state)
        S_RUN: begin
          if (commit_valid) match_cnt <= hit ? match_cnt + MW'(1) : '0;
          // A halt qualifying on the last allowed cycle beats the timeout.
          if (qualify) begin
            state <= S_CHECK;
          end else if (cyc_last) begin
            state                 <= S_TIMEOUT;
            running               <= 1'b0;
            done                  <= 1'b1;
            {timeout, fail, pass} <= res_flags(RES_TIMEOUT);
          end
        end
        S_CHECK: begin
          // gp is sampled here so an x3 writeback with the last commit counts.
          result_code           <= gp_value;
          state                 <= (chk_code == RES_PASS) ? S_PASS : S_FAIL;
          running               <= 1'b0;
          done                  <= 1'b1;
          {timeout, fail, pass} <= res_flags(chk_code);
        end
        default: ;
      endcase
    end
  end

`ifdef PROG_END_TRACE_EN
  logic [7:0][63:0] tbuf;
  logic [2:0]       wptr;
  logic [2:0]       rptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbuf <= '0;
      wptr <= '0;
    end else if (start) begin
      tbuf <= '0;
      wptr <= '0;
    end else if (in_run && commit_valid) begin
      tbuf[wptr] <= commit_pc;
      wptr       <= wptr + 3'd1;
    end
  end

  // wptr points at the next free slot; idx 0 is the newest entry.
  assign rptr     = wptr - 3'd1 - trace_idx;
  assign trace_pc = tbuf[rptr];
`endif

endmodule
